cache_req_issuer: RTL and testbench
===================================

# cache_req_issuer

Host-side initiator for the cache controller's operation interface. Accepts one host request (op, key, value) over a valid/ready handshake, drives `operation_e` plus key/value to the controller, holds it until the controller's `sub_cmd_t` done/error arrives or a timeout expires, then returns a status and read data over a second valid/ready handshake. It sits between the host bus adapter and the controller and is the only block that drives the controller's operation input.

## Interface
Parameters:
- KEY_WIDTH, 8, key bits
- VALUE_WIDTH, 64, value bits
- TIMEOUT_CYCLES, 255, maximum cycles waited for done/error, legal range 1..65535

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  host request valid
- req_ready_o  out  1  issuer can accept a request
- req_op_i  in  3  requested `operation_e`
- req_key_i  in  KEY_WIDTH  request key
- req_value_i  in  VALUE_WIDTH  upsert value
- op_o  out  3  `operation_e` to controller, NOOP when idle
- key_o  out  KEY_WIDTH  key to controller
- value_o  out  VALUE_WIDTH  value to controller
- ctrl_result_i  in  2  `sub_cmd_t` {done, error} from controller
- ctrl_value_i  in  VALUE_WIDTH  read data, valid with done on READ
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  host accepts response
- resp_status_o  out  2  `resp_status_e`
- resp_value_o  out  VALUE_WIDTH  read data, zero for non-READ

## Operation
- FSM `issuer_state_e`: IS_IDLE, IS_ISSUE, IS_RESP.
- IS_IDLE: req_ready_o=1, op_o=NOOP. On req_valid_i&req_ready_o latch op/key/value.
  - op is READ, UPSERT or DELETE -> IS_ISSUE, timeout counter cleared.
  - op is NOOP or 3'b100..3'b111 -> IS_RESP with status RS_ILLEGAL; controller never sees it.
- IS_ISSUE: op_o/key_o/value_o held constant from latched request; counter increments each cycle.
  - error=1 (regardless of done) -> IS_RESP, RS_ERROR; error wins over simultaneous done.
  - done=1, error=0 -> IS_RESP, RS_OK; resp_value_o latches ctrl_value_i if op was READ, else 0.
  - counter reaches TIMEOUT_CYCLES with neither -> IS_RESP, RS_TIMEOUT, resp_value_o=0.
  - done/error arriving in the same cycle as the timeout boundary take priority over timeout.
- IS_RESP: op_o=NOOP, resp_valid_o=1, status/value stable until resp_valid_o&resp_ready_i -> IS_IDLE.
- done/error observed outside IS_ISSUE are ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

## Timing
- Reset (async assert, sync release in effect via registered state): state IS_IDLE, op_o=NOOP, key_o=0, value_o=0, resp_valid_o=0, resp_status_o=RS_OK, resp_value_o=0, req_ready_o=1, counter=0.
- All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.
- Request accepted in cycle 0 -> op_o non-NOOP in cycle 1.
- done/error sampled in cycle k (k>=1) -> op_o=NOOP and resp_valid_o=1 in cycle k+1. Minimum accept-to-response latency 2 cycles.
- Illegal op accepted in cycle 0 -> resp_valid_o=1 in cycle 1.
- Timeout: op_o non-NOOP for exactly TIMEOUT_CYCLES cycles, resp_valid_o in the next cycle.
- After response handshake in cycle r, req_ready_o=1 in cycle r+1; controller always sees at least one NOOP cycle between operations. Throughput at most one request per 3 cycles.
- rst_n assertion mid-operation: immediate return to reset values; in-flight request and response discarded, op_o drops to NOOP asynchronously.

## Structure
- Add to ctrl_types_pkg: `resp_status_e` (RS_OK=0, RS_ERROR=1, RS_TIMEOUT=2, RS_ILLEGAL=3) and `issuer_state_e`; reuse existing `operation_e` and `sub_cmd_t`.
- Single module; no sub-module. Timeout counter inline.

## Test plan
- READ key 0x12, controller asserts done with ctrl_value_i=0xDEAD_BEEF 3 cycles after op_o=READ -> op_o=READ for 3 cycles, then resp RS_OK, resp_value_o=0xDEAD_BEEF, op_o=NOOP.
- UPSERT key 0x05 value 0x1234, done and error both asserted same cycle -> RS_ERROR, resp_value_o=0.
- DELETE with no controller response, TIMEOUT_CYCLES=4 -> op_o=DELETE exactly 4 cycles, then RS_TIMEOUT.
- req_op_i=3'b110 -> resp_valid_o in next cycle with RS_ILLEGAL, op_o stays NOOP throughout.
- Response back-pressure: resp_ready_i low 5 cycles -> resp_valid_o/status/value stable, req_ready_o=0, new req_valid_i not accepted until handshake.
- rst_n pulsed low while in IS_ISSUE with op_o=UPSERT -> op_o=NOOP immediately, resp_valid_o=0, req_ready_o=1 after release.

Source files
------------

// File: rtl/ctrl_types_pkg.sv
// Shared types for the cache controller and its host-side request issuer.
package ctrl_types_pkg;

  typedef enum logic [2:0] {
    NOOP   = 3'd0,
    READ   = 3'd1,
    UPSERT = 3'd2,
    DELETE = 3'd3
  } operation_e;

  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

  typedef enum logic [1:0] {
    RS_OK      = 2'd0,
    RS_ERROR   = 2'd1,
    RS_TIMEOUT = 2'd2,
    RS_ILLEGAL = 2'd3
  } resp_status_e;

  typedef enum logic [1:0] {
    IS_IDLE  = 2'd0,
    IS_ISSUE = 2'd1,
    IS_RESP  = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/cache_req_issuer.sv
// Host-side initiator: issues one operation to the cache controller, waits for
// done/error or timeout, and returns a status/read-data response to the host.
module cache_req_issuer
  import ctrl_types_pkg::*;
#(
  parameter int unsigned KEY_WIDTH      = 8,
  parameter int unsigned VALUE_WIDTH    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [2:0]             req_op_i,
  input  logic [KEY_WIDTH-1:0]   req_key_i,
  input  logic [VALUE_WIDTH-1:0] req_value_i,
  output logic [2:0]             op_o,
  output logic [KEY_WIDTH-1:0]   key_o,
  output logic [VALUE_WIDTH-1:0] value_o,
  input  logic [1:0]             ctrl_result_i,
  input  logic [VALUE_WIDTH-1:0] ctrl_value_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [1:0]             resp_status_o,
  output logic [VALUE_WIDTH-1:0] resp_value_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Last cycle of the wait window: op_o stays valid for exactly TIMEOUT_CYCLES cycles.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  issuer_state_e            state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic [KEY_WIDTH-1:0]     key_q, key_d;
  logic [VALUE_WIDTH-1:0]   value_q, value_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  resp_status_e             status_q, status_d;
  logic [VALUE_WIDTH-1:0]   rvalue_q, rvalue_d;
  sub_cmd_t                 result;
  logic                     legal_op;

  assign result   = sub_cmd_t'(ctrl_result_i);
  assign legal_op = (req_op_i == READ) || (req_op_i == UPSERT) || (req_op_i == DELETE);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    key_d    = key_q;
    value_d  = value_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    rvalue_d = rvalue_q;
    unique case (state_q)
      IS_IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          key_d   = req_key_i;
          value_d = req_value_i;
          cnt_d   = '0;
          if (legal_op) begin
            state_d = IS_ISSUE;
          end else begin
            state_d  = IS_RESP;
            status_d = RS_ILLEGAL;
            rvalue_d = '0;
          end
        end
      end
      IS_ISSUE: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Controller outcome beats a coincident timeout; error beats done.
        if (result.error) begin
          state_d  = IS_RESP;
          status_d = RS_ERROR;
          rvalue_d = '0;
        end else if (result.done) begin
          state_d  = IS_RESP;
          status_d = RS_OK;
          rvalue_d = (op_q == READ) ? ctrl_value_i : '0;
        end else if (cnt_q >= CntLast) begin
          state_d  = IS_RESP;
          status_d = RS_TIMEOUT;
          rvalue_d = '0;
        end
      end
      IS_RESP: begin
        if (resp_ready_i) begin
          state_d = IS_IDLE;
        end
      end
      default: state_d = IS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IS_IDLE;
      op_q     <= NOOP;
      key_q    <= '0;
      value_q  <= '0;
      cnt_q    <= '0;
      status_q <= RS_OK;
      rvalue_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      value_q  <= value_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      rvalue_q <= rvalue_d;
    end
  end

  assign req_ready_o   = (state_q == IS_IDLE);
  assign resp_valid_o  = (state_q == IS_RESP);
  assign op_o          = (state_q == IS_ISSUE) ? op_q : NOOP;
  assign key_o         = key_q;
  assign value_o       = value_q;
  assign resp_status_o = status_q;
  assign resp_value_o  = rvalue_q;

endmodule

// File: tb/tb_cache_req_issuer.sv
// Directed bench for cache_req_issuer with a short timeout window.
module tb_cache_req_issuer;
  import ctrl_types_pkg::*;

  localparam int unsigned KW = 8;
  localparam int unsigned VW = 64;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [2:0]    req_op_i = 3'd0;
  logic [KW-1:0] req_key_i = '0;
  logic [VW-1:0] req_value_i = '0;
  logic [2:0]    op_o;
  logic [KW-1:0] key_o;
  logic [VW-1:0] value_o;
  logic [1:0]    ctrl_result_i = 2'b00;
  logic [VW-1:0] ctrl_value_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic [1:0]    resp_status_o;
  logic [VW-1:0] resp_value_o;

  int vectors = 0;
  int miscompares = 0;

  cache_req_issuer #(
    .KEY_WIDTH     (KW),
    .VALUE_WIDTH   (VW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_key_i    (req_key_i),
    .req_value_i  (req_value_i),
    .op_o         (op_o),
    .key_o        (key_o),
    .value_o      (value_o),
    .ctrl_result_i(ctrl_result_i),
    .ctrl_value_i (ctrl_value_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_status_o(resp_status_o),
    .resp_value_o (resp_value_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set after this take effect at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_key_i   = key;
    req_value_i = val;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic handshake(input string tag);
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    chk({tag, "_ready_after"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_rvalid_after"}, 64'(resp_valid_o), 64'd0);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_op", 64'(op_o), 64'(NOOP));
    chk("rst_key", 64'(key_o), 64'd0);
    chk("rst_value", value_o, 64'd0);
    chk("rst_rvalid", 64'(resp_valid_o), 64'd0);
    chk("rst_status", 64'(resp_status_o), 64'(RS_OK));
    chk("rst_rvalue", resp_value_o, 64'd0);
    rst_n = 1'b1;
    step();

    // READ, done three cycles after op_o goes READ
    send(READ, 8'h12, 64'h0);
    chk("rd_op1", 64'(op_o), 64'(READ));
    chk("rd_key", 64'(key_o), 64'h12);
    chk("rd_ready", 64'(req_ready_o), 64'd0);
    step();
    chk("rd_op2", 64'(op_o), 64'(READ));
    step();
    chk("rd_op3", 64'(op_o), 64'(READ));
    ctrl_result_i = 2'b10;
    ctrl_value_i  = 64'hDEAD_BEEF;
    step();
    ctrl_result_i = 2'b00;
    chk("rd_op_noop", 64'(op_o), 64'(NOOP));
    chk("rd_rvalid", 64'(resp_valid_o), 64'd1);
    chk("rd_status", 64'(resp_status_o), 64'(RS_OK));
    chk("rd_rvalue", resp_value_o, 64'hDEAD_BEEF);
    handshake("rd");

    // UPSERT with done and error together: error wins
    send(UPSERT, 8'h05, 64'h1234);
    chk("up_op", 64'(op_o), 64'(UPSERT));
    chk("up_value", value_o, 64'h1234);
    ctrl_result_i = 2'b11;
    ctrl_value_i  = 64'hFFFF_0000;
    step();
    ctrl_result_i = 2'b00;
    chk("up_rvalid", 64'(resp_valid_o), 64'd1);
    chk("up_status", 64'(resp_status_o), 64'(RS_ERROR));
    chk("up_rvalue", resp_value_o, 64'd0);
    handshake("up");

    // DELETE with no controller reply: timeout after exactly TO cycles
    send(DELETE, 8'h33, 64'h0);
    n = 0;
    while (op_o == DELETE && n < 20) begin
      n++;
      step();
    end
    chk("del_cycles", 64'(n), 64'(TO));
    chk("del_rvalid", 64'(resp_valid_o), 64'd1);
    chk("del_status", 64'(resp_status_o), 64'(RS_TIMEOUT));
    chk("del_rvalue", resp_value_o, 64'd0);
    handshake("del");

    // READ with done on the final cycle of the window: done beats timeout
    send(READ, 8'h44, 64'h0);
    step();
    step();
    step();
    chk("bnd_op4", 64'(op_o), 64'(READ));
    ctrl_result_i = 2'b10;
    ctrl_value_i  = 64'h0000_00A5;
    step();
    ctrl_result_i = 2'b00;
    chk("bnd_status", 64'(resp_status_o), 64'(RS_OK));
    chk("bnd_rvalue", resp_value_o, 64'hA5);
    handshake("bnd");

    // Illegal op, then back-pressure with a pending new request and stray done
    send(3'b110, 8'h01, 64'h0);
    chk("ill_rvalid", 64'(resp_valid_o), 64'd1);
    chk("ill_status", 64'(resp_status_o), 64'(RS_ILLEGAL));
    chk("ill_op", 64'(op_o), 64'(NOOP));
    req_valid_i   = 1'b1;
    req_op_i      = READ;
    req_key_i     = 8'h77;
    ctrl_result_i = 2'b10;
    ctrl_value_i  = 64'h5555;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rvalid", 64'(resp_valid_o), 64'd1);
      chk("bp_status", 64'(resp_status_o), 64'(RS_ILLEGAL));
      chk("bp_rvalue", resp_value_o, 64'd0);
      chk("bp_ready", 64'(req_ready_o), 64'd0);
      chk("bp_op", 64'(op_o), 64'(NOOP));
    end
    ctrl_result_i = 2'b00;
    req_valid_i   = 1'b0;
    handshake("bp");
    chk("bp_op_idle", 64'(op_o), 64'(NOOP));

    // Asynchronous reset while an UPSERT is in flight
    send(UPSERT, 8'h09, 64'hABCD);
    chk("rs_op", 64'(op_o), 64'(UPSERT));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_op_async", 64'(op_o), 64'(NOOP));
    chk("rs_rvalid", 64'(resp_valid_o), 64'd0);
    chk("rs_ready", 64'(req_ready_o), 64'd1);
    chk("rs_key", 64'(key_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rs_ready_rel", 64'(req_ready_o), 64'd1);
    chk("rs_op_rel", 64'(op_o), 64'(NOOP));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
